// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch and load/store,
// data-first with a burst cap against fetch starvation and a watchdog abort.
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MAX_D_BURST = 4,
  parameter int TIMEOUT = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            if_req_i,
  input  logic [AW-1:0]   if_addr_i,
  output logic [DW-1:0]   if_rdata_o,
  output logic            if_done_o,
  input  logic            d_req_i,
  input  logic            d_we_i,
  input  logic [DW/8-1:0] d_be_i,
  input  logic [AW-1:0]   d_addr_i,
  input  logic [DW-1:0]   d_wdata_i,
  output logic [DW-1:0]   d_rdata_o,
  output logic            d_done_o,
  output logic            bus_err_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [DW/8-1:0] mem_be_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic [DW-1:0]   mem_wdata_o,
  input  logic            mem_ready_i,
  input  logic [DW-1:0]   mem_rdata_i,
  output logic            stall_o
);
  localparam int BW = $clog2(MAX_D_BURST + 1);
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [BW-1:0] B_MAX = BW'(MAX_D_BURST);
  localparam logic [WW-1:0] W_MAX = WW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  state_e state_q, state_d;
  logic gnt_d_q, gnt_d_d, pick_data;
  logic [BW-1:0] burst_q, burst_d;
  logic [WW-1:0] wd_q, wd_d;
  logic mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [DW/8-1:0] mem_be_q, mem_be_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d, if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic if_done_q, if_done_d, d_done_q, d_done_d, bus_err_q, bus_err_d;
  assign pick_data   = d_req_i & ~(if_req_i & (burst_q == B_MAX));
  assign if_rdata_o  = if_rdata_q;
  assign if_done_o   = if_done_q;
  assign d_rdata_o   = d_rdata_q;
  assign d_done_o    = d_done_q;
  assign bus_err_o   = bus_err_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_be_o    = mem_be_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign stall_o     = (if_req_i & ~if_done_q) | (d_req_i & ~d_done_q);
  always_comb begin
    state_d     = state_q;
    gnt_d_d     = gnt_d_q;
    burst_d     = burst_q;
    wd_d        = wd_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    bus_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // A data grant while fetch waits extends the burst; anything else restarts it.
        burst_d = (pick_data & if_req_i) ? burst_q + 1'b1 : '0;
        if (if_req_i | d_req_i) begin
          state_d     = BUSY;
          gnt_d_d     = pick_data;
          mem_req_d   = 1'b1;
          mem_we_d    = pick_data & d_we_i;
          mem_be_d    = pick_data ? d_be_i : '1;
          mem_addr_d  = pick_data ? d_addr_i : if_addr_i;
          mem_wdata_d = pick_data ? d_wdata_i : '0;
        end
      end
      BUSY: begin
        if (mem_ready_i | (wd_q == W_MAX)) begin
          state_d    = DONE;
          mem_req_d  = 1'b0;
          wd_d       = '0;
          if_done_d  = ~gnt_d_q;
          d_done_d   = gnt_d_q;
          bus_err_d  = ~mem_ready_i;
          if_rdata_d = gnt_d_q ? if_rdata_q : (mem_ready_i ? mem_rdata_i : '0);
          d_rdata_d  = gnt_d_q ? (mem_ready_i ? mem_rdata_i : '0) : d_rdata_q;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      gnt_d_q     <= 1'b0;
      burst_q     <= '0;
      wd_q        <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_d_q     <= gnt_d_d;
      burst_q     <= burst_d;
      wd_q        <= wd_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
      bus_err_q   <= bus_err_d;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random requesters and memory against a transaction-timeline model.
module tb_mem_port_arbiter;
  localparam int MAXB = 4;
  localparam int TMO = 64;
  logic clk = 1'b0, rst_ni = 1'b0;
  logic if_req = 0, d_req = 0, d_we = 0, mem_ready = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
  logic [3:0] d_be = 0;
  logic [31:0] if_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o;
  logic [3:0] mem_be_o;
  logic if_done_o, d_done_o, bus_err_o, mem_req_o, mem_we_o, stall_o;
  always #5 clk = ~clk;
  mem_port_arbiter #(.AW(32), .DW(32), .MAX_D_BURST(MAXB), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata_o),
    .if_done_o(if_done_o), .d_req_i(d_req), .d_we_i(d_we), .d_be_i(d_be), .d_addr_i(d_addr),
    .d_wdata_i(d_wdata), .d_rdata_o(d_rdata_o), .d_done_o(d_done_o), .bus_err_o(bus_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata), .stall_o(stall_o));
  int cyc = 0, n_cmp = 0, n_fail = 0;
  int p_if = 0, p_d = 0, wait_fix = -1, we_mode = -1;
  bit d_fix = 0, rd_fix = 0, rel = 0, in_rst = 1;
  logic [31:0] rd_val = 0;
  // Model: one transaction granted at sample cycle s, mem_req for m cycles, done at s+m+1.
  bit act = 0, who_d = 0, tmo = 0, pd_if = 0, pd_d = 0;
  int s = 0, m = 0, next_sample = 1 << 30, burst = 0;
  logic g_we = 0;
  logic [3:0] g_be = 0;
  logic [31:0] g_addr = 0, g_wdata = 0, cap = 0, e_ifr = 0, e_dr = 0;
  int gcount = 0, gcyc[$], reqcnt = 0, last_done = 0, done_cnt = 0;
  logic [31:0] gbits = 0, sn_addr = 0;
  logic [3:0] sn_be = 0;
  logic sn_we = 0, sn_err = 0;
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, cyc);
    end
  endtask
  task automatic tick();
    bit e_req, e_ifd, e_dd, e_err, fin;
    int t;
    @(negedge clk);
    t = cyc;
    fin = act && t == s + m + 1;
    e_req = act && t >= s + 1 && t <= s + m;
    e_ifd = fin && !who_d;
    e_dd = fin && who_d;
    e_err = fin && tmo;
    if (fin) begin
      if (who_d) e_dr = tmo ? 32'h0 : cap;
      else e_ifr = tmo ? 32'h0 : cap;
    end
    chk("mem_req", mem_req_o, e_req);
    chk("if_done", if_done_o, e_ifd);
    chk("d_done", d_done_o, e_dd);
    chk("bus_err", bus_err_o, e_err);
    chk("if_rdata", if_rdata_o, e_ifr);
    chk("d_rdata", d_rdata_o, e_dr);
    if (e_req) begin
      chk("mem_we", mem_we_o, g_we);
      chk("mem_be", mem_be_o, g_be);
      chk("mem_addr", mem_addr_o, g_addr);
      if (g_we) chk("mem_wdata", mem_wdata_o, g_wdata);
      sn_we = mem_we_o; sn_be = mem_be_o; sn_addr = mem_addr_o;
    end
    if (mem_req_o) reqcnt++;
    if (fin) begin
      done_cnt++; last_done = t; sn_err = bus_err_o; act = 0;
    end
    if (rel) begin
      rst_ni = 1'b1; rel = 0; in_rst = 0; next_sample = t;
    end
    if (in_rst) begin
      if_req = 0; d_req = 0;
    end else begin
      if (!if_req || pd_if) begin
        if_req = $urandom_range(0, 99) < p_if;
        if_addr = $urandom & ~32'h3;
      end
      if (!d_req || pd_d) begin
        d_req = $urandom_range(0, 99) < p_d;
        d_we = we_mode < 0 ? 1'($urandom % 2) : (we_mode == 1);
        d_be = 4'($urandom); d_addr = $urandom; d_wdata = $urandom;
        if (d_fix) begin
          d_addr = 32'h100; d_be = 4'b0011; d_wdata = 32'h1234;
        end
      end
    end
    pd_if = e_ifd;
    pd_d = e_dd;
    if (t == next_sample) begin
      if (!if_req) burst = 0;
      if (if_req || d_req) begin
        who_d = d_req && !(if_req && burst == MAXB);
        if (!who_d) burst = 0;
        else if (if_req && burst < MAXB) burst++;
        tmo = wait_fix == -2 || (wait_fix == -1 && $urandom_range(0, 15) == 0);
        m = tmo ? TMO : (wait_fix >= 0 ? wait_fix + 1 : int'($urandom_range(1, 4)));
        s = t; act = 1; next_sample = t + m + 2;
        g_we = who_d & d_we;
        g_be = who_d ? d_be : 4'hF;
        g_addr = who_d ? d_addr : if_addr;
        g_wdata = d_wdata;
        gcount++; gbits = {gbits[30:0], who_d}; gcyc.push_back(t);
      end else next_sample = t + 1;
    end
    mem_rdata = rd_fix ? rd_val : $urandom;
    mem_ready = act && !tmo && t == s + m;
    if (mem_ready) cap = mem_rdata;
    #1 chk("stall", stall_o, (if_req & !e_ifd) | (d_req & !e_dd));
    cyc++;
  endtask
  task automatic wait_g(int n, int budget);
    for (int k = 0; k < budget && gcount < n; k++) tick();
    n_cmp++;
    if (gcount < n) begin
      n_fail++; $display("FAIL wait_grant: got %0d grants expected %0d", gcount, n);
    end
  endtask
  task automatic wait_done(int n, int budget);
    for (int k = 0; k < budget && done_cnt < n; k++) tick();
    n_cmp++;
    if (done_cnt < n) begin
      n_fail++; $display("FAIL wait_done: got %0d dones expected %0d", done_cnt, n);
    end
  endtask
  task automatic drain();
    p_if = 0; p_d = 0;
    for (int k = 0; k < 300 && (act || if_req || d_req); k++) tick();
    tick();
    chk("drain_idle", {31'b0, act | if_req | d_req}, 0);
  endtask
  initial begin
    int t0, g0, dc0;
    repeat (2) tick();
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_d_rdata", d_rdata_o, 0);
    rel = 1;
    tick();
    // single load, two wait cycles
    p_d = 100; we_mode = 0; wait_fix = 2; rd_fix = 1; rd_val = 32'hDEADBEEF;
    reqcnt = 0; dc0 = done_cnt; g0 = gcount;
    wait_g(g0 + 1, 5);
    t0 = gcyc[$]; p_d = 0;
    wait_done(dc0 + 1, 10);
    tick();
    chk("load_req_cycles", reqcnt, 3);
    chk("load_latency", last_done - t0, 4);
    chk("load_rdata", d_rdata_o, 32'hDEADBEEF);
    chk("load_we", {31'b0, sn_we}, 0);
    rd_fix = 0;
    // directed store
    d_fix = 1; we_mode = 1; p_d = 100; wait_fix = 1; dc0 = done_cnt; g0 = gcount;
    wait_g(g0 + 1, 5);
    p_d = 0;
    wait_done(dc0 + 1, 10);
    chk("store_we", {31'b0, sn_we}, 1);
    chk("store_be", {28'b0, sn_be}, 4'b0011);
    chk("store_addr", sn_addr, 32'h100);
    chk("store_if_rdata", if_rdata_o, 0);
    d_fix = 0; we_mode = -1;
    drain();
    // both held continuously, zero-wait memory
    wait_fix = 0; p_if = 100; p_d = 100; g0 = gcount;
    wait_g(g0 + 10, 60);
    chk("burst_order", gbits[9:0], 10'b1111011110);
    chk("burst_spacing", gcyc[$] - gcyc[$-9], 27);
    drain();
    // watchdog abort, then a normal transaction
    wait_fix = -2; reqcnt = 0; p_d = 100; dc0 = done_cnt; g0 = gcount;
    wait_g(g0 + 1, 5);
    t0 = gcyc[$]; p_d = 0;
    wait_done(dc0 + 1, 80);
    chk("tmo_req_cycles", reqcnt, TMO);
    chk("tmo_latency", last_done - t0, TMO + 1);
    chk("tmo_err", {31'b0, sn_err}, 1);
    chk("tmo_rdata", d_rdata_o, 0);
    wait_fix = 0; p_d = 100; dc0 = done_cnt; g0 = gcount;
    wait_g(g0 + 1, 5);
    p_d = 0;
    wait_done(dc0 + 1, 10);
    chk("after_tmo_err", {31'b0, sn_err}, 0);
    drain();
    // reset in the middle of a transaction after a burst of three data grants
    p_if = 100; p_d = 100; wait_fix = 3; g0 = gcount;
    wait_g(g0 + 4, 60);
    tick(); tick();
    @(posedge clk);
    #2 rst_ni = 1'b0;
    #1 chk("rst_async_req", mem_req_o, 0);
    chk("rst_no_done", {31'b0, d_done_o | if_done_o}, 0);
    act = 0; burst = 0; e_ifr = 0; e_dr = 0; pd_if = 0; pd_d = 0; in_rst = 1;
    next_sample = 1 << 30; if_req = 0; d_req = 0; mem_ready = 0;
    tick(); tick();
    rel = 1; wait_fix = 0; g0 = gcount;
    wait_g(g0 + 5, 40);
    chk("rst_burst_order", gbits[4:0], 5'b11110);
    drain();
    // fetch only, back to back
    p_if = 100; wait_fix = 0; g0 = gcount;
    wait_g(g0 + 5, 30);
    chk("fetch_spacing", gcyc[$] - gcyc[$-4], 12);
    chk("fetch_order", gbits[4:0], 0);
    drain();
    // random traffic
    p_if = 40; p_d = 40; wait_fix = -1; we_mode = -1;
    repeat (2000) tick();
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
